nios2_debug_action_sequencer: RTL

- Sits between the debug-slave sysclk action decoder and the shared OCI resource (OCI memory, break registers, trace control).
- Captures single-cycle take_action / take_no_action strobes together with the jdo word, and queues them in a small FIFO.
- Issues the queued commands one at a time over a valid/ack handshake.
- Timeout and overflow are reported through sticky error flags.

---
 rtl/nios2_debug_action_sequencer_if.sv | 67 ++++++
 rtl/nios2_debug_action_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/nios2_debug_action_sequencer_if.sv
// ---------------------------------------------------------------------------
// nios2_debug_action_sequencer_if
//
// Purpose:
//   Groups the signals exchanged between the debug action sequencer and its
//   surroundings. The surroundings are the sysclk action decoder, which drives
//   the strobes and jdo, and the OCI resource, which receives commands and
//   drives cmd_ack.
//
// Signal summary:
//   take_action_* / take_no_action_*  single-cycle command strobes (types 0..6)
//   jdo           payload sampled together with a strobe
//   cmd_ack       resource accepted the presented command
//   clear_err     clears the sticky error flags
//   cmd_valid     a command is being presented
//   cmd_type      3-bit command code
//   cmd_jdo       command payload
//   busy          queue non-empty or command outstanding
//   fifo_level    current queue occupancy
//   overflow_err  sticky: a strobe was dropped
//   timeout_err   sticky: a command was aborted by timeout
//
// Modports:
//   slave   the sequencer itself
//   master  the environment (decoder + resource)
// ---------------------------------------------------------------------------
interface nios2_debug_action_sequencer_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int JDO_WIDTH  = 38
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                 take_action_ocimem_a;
  logic                 take_action_ocimem_b;
  logic                 take_no_action_ocimem_a;
  logic                 take_action_break_a;
  logic                 take_action_break_b;
  logic                 take_action_break_c;
  logic                 take_action_tracectrl;
  logic [JDO_WIDTH-1:0] jdo;
  logic                 cmd_ack;
  logic                 clear_err;

  logic                 cmd_valid;
  logic [2:0]           cmd_type;
  logic [JDO_WIDTH-1:0] cmd_jdo;
  logic                 busy;
  logic [LW-1:0]        fifo_level;
  logic                 overflow_err;
  logic                 timeout_err;

  modport slave (
    input  take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
           take_action_break_a, take_action_break_b, take_action_break_c,
           take_action_tracectrl, jdo, cmd_ack, clear_err,
    output cmd_valid, cmd_type, cmd_jdo, busy, fifo_level,
           overflow_err, timeout_err
  );

  modport master (
    output take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
           take_action_break_a, take_action_break_b, take_action_break_c,
           take_action_tracectrl, jdo, cmd_ack, clear_err,
    input  cmd_valid, cmd_type, cmd_jdo, busy, fifo_level,
           overflow_err, timeout_err
  );
endinterface

// File: rtl/nios2_debug_action_sequencer.sv
// ---------------------------------------------------------------------------
// nios2_debug_action_sequencer
//
// Purpose:
//   Captures single-cycle debug action strobes together with the jdo word.
//   Queues them in a small FIFO and issues them one at a time to the shared
//   OCI resource over a valid/ack handshake. Dropped strobes and timed-out
//   commands are reported through sticky error flags.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      nios2_debug_action_sequencer_if.slave (strobes, jdo, cmd_ack,
//            clear_err in; cmd_valid, cmd_type, cmd_jdo, busy, fifo_level,
//            overflow_err, timeout_err out)
//
// Parameters:
//   FIFO_DEPTH      queue entries, power of two, >= 2
//   TIMEOUT_CYCLES  max cycles cmd_valid may wait for cmd_ack (0 = never)
//   JDO_WIDTH       payload width
// ---------------------------------------------------------------------------
module nios2_debug_action_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int JDO_WIDTH      = 38
) (
  input logic                           clk,
  input logic                           reset_n,
  nios2_debug_action_sequencer_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 3 + JDO_WIDTH;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [6:0]    w_strobes;
  logic          w_anyStrobe;
  logic          w_multiStrobe;
  logic [2:0]    w_winType;

  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [EW-1:0] w_head;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  logic [0:0]           r_state;
  logic                 r_cmdValid;
  logic [2:0]           r_cmdType;
  logic [JDO_WIDTH-1:0] r_cmdJdo;
  logic [CW-1:0]        r_toCount;
  logic                 w_timeoutHit;

  logic r_overflowErr;
  logic r_timeoutErr;

  // Bit i of the strobe vector corresponds to cmd_type i.
  assign w_strobes = {bus.take_action_tracectrl,
                      bus.take_action_break_c,
                      bus.take_action_break_b,
                      bus.take_action_break_a,
                      bus.take_no_action_ocimem_a,
                      bus.take_action_ocimem_b,
                      bus.take_action_ocimem_a};

  assign w_anyStrobe   = |w_strobes;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign w_multiStrobe = (w_strobes & (w_strobes - 7'd1)) != 7'd0;

  // Lowest type number wins; scanning downward lets the smallest index
  // overwrite any higher one.
  always_comb begin
    w_winType = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (w_strobes[i]) w_winType = 3'(i);
    end
  end

  // The extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_head  = r_mem[r_rdPtr[AW-1:0]];

  // A pop in the same cycle frees the slot, so a full queue can still take
  // a strobe then.
  assign w_pop  = (r_state == IDLE) && !w_empty;
  assign w_push = w_anyStrobe && (!w_full || w_pop);
  assign w_drop = w_multiStrobe || (w_anyStrobe && w_full && !w_pop);

  // Ack has precedence over the timeout when both land on the same edge.
  assign w_timeoutHit = (r_state == ISSUE) && !bus.cmd_ack &&
                        (TIMEOUT_CYCLES != 0) && (r_toCount == TO_LAST);

  // Queue storage holds no control state, so it is left unreset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr[AW-1:0]] <= {w_winType, bus.jdo};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
    end
  end

  // Issue FSM: IDLE pops the head into the output registers; ISSUE holds
  // it until ack or timeout, after which the command is retired.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cmdValid <= 1'b0;
      r_cmdType  <= 3'd0;
      r_cmdJdo   <= '0;
      r_toCount  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_cmdType  <= w_head[EW-1 -: 3];
            r_cmdJdo   <= w_head[JDO_WIDTH-1:0];
            r_cmdValid <= 1'b1;
            r_toCount  <= '0;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.cmd_ack || w_timeoutHit) begin
            r_cmdValid <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_toCount <= r_toCount + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sticky flags: a new error in the same cycle overrides clear_err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflowErr <= 1'b0;
      r_timeoutErr  <= 1'b0;
    end else begin
      if (w_drop)             r_overflowErr <= 1'b1;
      else if (bus.clear_err) r_overflowErr <= 1'b0;
      if (w_timeoutHit)       r_timeoutErr  <= 1'b1;
      else if (bus.clear_err) r_timeoutErr  <= 1'b0;
    end
  end

  assign bus.cmd_valid    = r_cmdValid;
  assign bus.cmd_type     = r_cmdType;
  assign bus.cmd_jdo      = r_cmdJdo;
  assign bus.busy         = !w_empty || r_cmdValid;
  assign bus.fifo_level   = r_wrPtr - r_rdPtr;
  assign bus.overflow_err = r_overflowErr;
  assign bus.timeout_err  = r_timeoutErr;

endmodule
